mem_image_loader: RTL and testbench

Host-side initiator for the datapath's external memory-load interface. It accepts a program image as a stream of 32-bit words and packs them into 64-bit write beats on the instruction-memory and data-memory load ports. It owns the load-enable strobe, holds the pipeline in load/flush while loading, and then releases the core to run. It sits between the test bench or host link and the datapath's load and halt inputs.

---
 rtl/mem_image_loader_pkg.sv | 22 ++
 rtl/mem_image_loader_word_pair_packer.sv | 57 +++++
 rtl/mem_image_loader.sv | 137 +++++++++++++
 tb/tb_mem_image_loader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_image_loader_pkg.sv
// Shared types for the memory image loader: FSM state encoding and the
// 64-bit write beat presented on the instruction/data memory load ports.
package mem_image_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_INST = 3'd1,
    S_LOAD_DATA = 3'd2,
    S_FLUSH     = 3'd3,
    S_RUN       = 3'd4
  } loader_state_t;

  localparam int BEAT_BYTES  = 8;
  localparam int BEAT_ADDR_W = 16;

  typedef struct packed {
    logic [BEAT_ADDR_W-1:0] addr;
    logic [31:0]            data1;
    logic [31:0]            data2;
  } beat_t;

endpackage

// File: rtl/mem_image_loader_word_pair_packer.sv
// Pairs 32-bit words into 64-bit beats, pads an odd final word with zero,
// generates beat byte addresses and flags beats that fall beyond the memory.
module word_pair_packer
  import mem_image_loader_pkg::*;
#(
  parameter int ADDR_W    = 9,
  parameter int MEM_BYTES = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [31:0] data,
  input  logic        last,
  output logic        fire,
  output logic        ovf,
  output beat_t       beat
);

  // One extra bit so an out-of-range beat address is representable.
  localparam int NA_W = ADDR_W + 1;
  localparam logic [NA_W-1:0] LAST_ADDR = NA_W'(MEM_BYTES - BEAT_BYTES);

  logic              half;
  logic [31:0]       first;
  logic [NA_W-1:0]   next_addr;

  assign fire = accept && (half || last);
  assign ovf  = fire && (next_addr > LAST_ADDR);

  always_comb begin
    beat.addr  = BEAT_ADDR_W'(next_addr);
    beat.data1 = half ? first : data;
    beat.data2 = half ? data : 32'h0;
  end

  // Once overflowed, next_addr stops advancing so it can never wrap back in range.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      half      <= 1'b0;
      first     <= '0;
      next_addr <= '0;
    end else if (accept) begin
      if (last) begin
        half      <= 1'b0;
        next_addr <= '0;
      end else if (!half) begin
        half  <= 1'b1;
        first <= data;
      end else begin
        half <= 1'b0;
        if (!ovf) next_addr <= next_addr + NA_W'(BEAT_BYTES);
      end
    end
  end

endmodule

// File: rtl/mem_image_loader.sv
// Host-side image loader: packs a word stream into 64-bit load beats, then
// flushes and releases the core. Optional checksum via MEM_LOADER_CHECKSUM_EN.
module mem_image_loader
  import mem_image_loader_pkg::*;
#(
  parameter int ADDR_W       = 9,
  parameter int MEM_BYTES    = 512,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt_req,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  output logic              enable_load_ex_mem,
  output logic              enable_half,
  output logic [ADDR_W-1:0] InstExMemAddress,
  output logic [31:0]       InstExMemData1,
  output logic [31:0]       InstExMemData2,
  output logic [ADDR_W-1:0] DataExMemAddress,
  output logic [31:0]       DataExMemData1,
  output logic [31:0]       DataExMemData2,
  output logic              busy,
  output logic              done,
  output logic              overflow_err,
  output logic [2:0]        fsm_state
`ifdef MEM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  loader_state_t    state;
  logic [CNT_W-1:0] flush_cnt;
  logic             loading, accept, restart, fire, ovf;
  beat_t            beat;
  logic             unused_addr_hi;

  // Handshake: a word transfers on a rising edge where s_valid && s_ready;
  // s_ready is high for every cycle of LOAD_INST/LOAD_DATA and never stalls.
  assign loading            = (state == S_LOAD_INST) || (state == S_LOAD_DATA);
  assign s_ready            = loading;
  assign accept             = s_valid && loading;
  assign restart            = start && ((state == S_IDLE) || (state == S_RUN));
  assign enable_load_ex_mem = loading || (state == S_FLUSH);
  assign busy               = enable_load_ex_mem;
  assign enable_half        = (state == S_RUN) ? halt_req : (state == S_IDLE);
  assign fsm_state          = state;
  assign unused_addr_hi     = ^beat.addr[BEAT_ADDR_W-1:ADDR_W];

  word_pair_packer #(
    .ADDR_W    (ADDR_W),
    .MEM_BYTES (MEM_BYTES)
  ) u_packer (
    .clk    (clk),
    .reset  (reset),
    .clear  (restart),
    .accept (accept),
    .data   (s_data),
    .last   (s_last),
    .fire   (fire),
    .ovf    (ovf),
    .beat   (beat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      flush_cnt        <= '0;
      done             <= 1'b0;
      overflow_err     <= 1'b0;
      InstExMemAddress <= '0;
      InstExMemData1   <= '0;
      InstExMemData2   <= '0;
      DataExMemAddress <= '0;
      DataExMemData1   <= '0;
      DataExMemData2   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_RUN: begin
          if (start) begin
            state            <= S_LOAD_INST;
            overflow_err     <= 1'b0;
            InstExMemAddress <= '0;
            InstExMemData1   <= '0;
            InstExMemData2   <= '0;
            DataExMemAddress <= '0;
            DataExMemData1   <= '0;
            DataExMemData2   <= '0;
          end
        end
        S_LOAD_INST, S_LOAD_DATA: begin
          if (fire) begin
            if (ovf) begin
              overflow_err <= 1'b1;
            end else if (state == S_LOAD_INST) begin
              InstExMemAddress <= beat.addr[ADDR_W-1:0];
              InstExMemData1   <= beat.data1;
              InstExMemData2   <= beat.data2;
            end else begin
              DataExMemAddress <= beat.addr[ADDR_W-1:0];
              DataExMemData1   <= beat.data1;
              DataExMemData2   <= beat.data2;
            end
          end
          if (accept && s_last) begin
            flush_cnt <= '0;
            state     <= (state == S_LOAD_INST) ? S_LOAD_DATA : S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (flush_cnt == CNT_W'(FLUSH_CYCLES - 1)) begin
            state <= S_RUN;
            done  <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || restart) checksum <= '0;
    else if (accept)      checksum <= checksum + s_data;
  end
`endif

endmodule

// File: tb/tb_mem_image_loader.sv
// Self-checking bench for mem_image_loader: random word streams checked
// against a beat scoreboard built from the word lists.
module tb_mem_image_loader;
  import mem_image_loader_pkg::*;

  localparam int ADDR_W       = 9;
  localparam int MEM_BYTES    = 256;
  localparam int FLUSH_CYCLES = 2;

  typedef logic [31:0] word_q_t[$];

  logic              clk = 1'b0;
  logic              reset, start, halt_req, s_valid, s_ready, s_last;
  logic [31:0]       s_data;
  logic              enable_load_ex_mem, enable_half, busy, done, overflow_err;
  logic [ADDR_W-1:0] InstExMemAddress, DataExMemAddress;
  logic [31:0]       InstExMemData1, InstExMemData2, DataExMemData1, DataExMemData2;
  logic [2:0]        fsm_state;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [31:0]       checksum;
`endif

  mem_image_loader #(
    .ADDR_W       (ADDR_W),
    .MEM_BYTES    (MEM_BYTES),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .halt_req           (halt_req),
    .s_valid            (s_valid),
    .s_ready            (s_ready),
    .s_data             (s_data),
    .s_last             (s_last),
    .enable_load_ex_mem (enable_load_ex_mem),
    .enable_half        (enable_half),
    .InstExMemAddress   (InstExMemAddress),
    .InstExMemData1     (InstExMemData1),
    .InstExMemData2     (InstExMemData2),
    .DataExMemAddress   (DataExMemAddress),
    .DataExMemData1     (DataExMemData1),
    .DataExMemData2     (DataExMemData2),
    .busy               (busy),
    .done               (done),
    .overflow_err       (overflow_err),
    .fsm_state          (fsm_state)
`ifdef MEM_LOADER_CHECKSUM_EN
    ,
    .checksum           (checksum)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  // Scoreboard state
  int          errors = 0;
  int          checks = 0;
  logic [79:0] exp_q[$];
  logic        cur_inst;
  logic [ADDR_W-1:0] exp_inst_addr, exp_data_addr;
  logic [31:0] exp_inst_d1, exp_inst_d2, exp_data_d1, exp_data_d2, exp_sum;
  logic        exp_ovf;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_inst_addr = '0; exp_inst_d1 = '0; exp_inst_d2 = '0;
    exp_data_addr = '0; exp_data_d1 = '0; exp_data_d2 = '0;
    exp_ovf = 1'b0; exp_sum = '0;
    exp_q = {};
  endtask

  task automatic check_ports(input string tag);
    check_eq({tag, ".inst_addr"}, 32'(InstExMemAddress), 32'(exp_inst_addr));
    check_eq({tag, ".inst_d1"},   InstExMemData1, exp_inst_d1);
    check_eq({tag, ".inst_d2"},   InstExMemData2, exp_inst_d2);
    check_eq({tag, ".data_addr"}, 32'(DataExMemAddress), 32'(exp_data_addr));
    check_eq({tag, ".data_d1"},   DataExMemData1, exp_data_d1);
    check_eq({tag, ".data_d2"},   DataExMemData2, exp_data_d2);
    check_eq({tag, ".ovf"},       32'(overflow_err), 32'(exp_ovf));
`ifdef MEM_LOADER_CHECKSUM_EN
    check_eq({tag, ".checksum"},  checksum, exp_sum);
`endif
  endtask

  task automatic check_ctrl(input string tag, input logic ld, input logic hf,
                            input logic rdy, input logic bsy, input logic dn);
    check_eq({tag, ".enable_load"}, 32'(enable_load_ex_mem), 32'(ld));
    check_eq({tag, ".enable_half"}, 32'(enable_half), 32'(hf));
    check_eq({tag, ".s_ready"},     32'(s_ready), 32'(rdy));
    check_eq({tag, ".busy"},        32'(busy), 32'(bsy));
    check_eq({tag, ".done"},        32'(done), 32'(dn));
  endtask

  // Expected beats of a segment: pair k lands at byte 8k, odd tail padded with 0.
  task automatic build_beats(input word_q_t w);
    logic [31:0] d2;
    for (int p = 0; 2 * p < w.size(); p++) begin
      d2 = (2 * p + 1 < w.size()) ? w[2 * p + 1] : 32'h0;
      exp_q.push_back({16'(p * 8), w[2 * p], d2});
    end
  endtask

  task automatic apply_beat();
    logic [79:0] b;
    if (exp_q.size() == 0) begin
      check_eq("beat_underflow", 32'(exp_q.size()), 32'd1);
      return;
    end
    b = exp_q.pop_front();
    if (b[79:64] > 16'(MEM_BYTES - 8)) exp_ovf = 1'b1;
    else if (cur_inst) begin
      exp_inst_addr = b[64 +: ADDR_W]; exp_inst_d1 = b[63:32]; exp_inst_d2 = b[31:0];
    end else begin
      exp_data_addr = b[64 +: ADDR_W]; exp_data_d1 = b[63:32]; exp_data_d2 = b[31:0];
    end
  endtask

  function automatic word_q_t rand_words(input int n);
    word_q_t q;
    for (int i = 0; i < n; i++) q.push_back($urandom);
    return q;
  endfunction

  // Driver: gap_mode 0 = back-to-back, 1 = valid every other cycle, 2 = random gaps.
  task automatic send_segment(input word_q_t w, input int gap_mode);
    int gap;
    build_beats(w);
    for (int i = 0; i < w.size(); i++) begin
      gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
      repeat (gap) begin
        s_valid = 1'b0; s_data = $urandom; s_last = 1'($urandom_range(0, 1));
        @(negedge clk);
        check_ports("gap");
      end
      check_eq("s_ready_load", 32'(s_ready), 32'd1);
      s_valid = 1'b1; s_data = w[i]; s_last = (i == w.size() - 1);
      @(negedge clk);
      s_valid = 1'b0; s_last = 1'b0;
      exp_sum = exp_sum + w[i];
      if ((i % 2 == 1) || (i == w.size() - 1)) apply_beat();
      check_ports("beat");
    end
    check_eq("beats_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_load(input word_q_t iq, input word_q_t dq, input int gap_mode);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_clear();
    check_ctrl("load_entry", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check_ports("load_entry");
    cur_inst = 1'b1;
    send_segment(iq, gap_mode);
    cur_inst = 1'b0;
    send_segment(dq, gap_mode);
    for (int c = 0; c < FLUSH_CYCLES; c++) begin
      check_ctrl("flush", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      check_ports("flush");
      s_valid = 1'b1; s_data = $urandom; s_last = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    s_valid = 1'b0; s_last = 1'b0;
    check_ctrl("run_entry", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_ports("run_entry");
    @(negedge clk);
    check_ctrl("run", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    word_q_t iq, dq;
    reset = 1'b1; start = 1'b0; halt_req = 1'b0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; cur_inst = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    check_eq("reset_state", 32'(fsm_state), 32'(S_IDLE));
    check_ctrl("reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_ports("reset");
    reset = 1'b0;
    @(negedge clk);
    check_ctrl("idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Four instruction words, two data words
    do_load(rand_words(4), rand_words(2), 0);
    // Odd instruction segment
    do_load(rand_words(3), rand_words(3), 0);
    // valid toggling every other cycle
    do_load(rand_words(8), rand_words(5), 1);
    // Overflow: 66 words into a 256-byte memory
    do_load(rand_words(66), rand_words(2), 0);
    check_eq("ovf_sticky", 32'(overflow_err), 32'd1);
    check_eq("ovf_inst_addr", 32'(InstExMemAddress), 32'd248);

    // Halt in RUN is combinational
    halt_req = 1'b1; #1;
    check_eq("halt_on", 32'(enable_half), 32'd1);
    halt_req = 1'b0; #1;
    check_eq("halt_off", 32'(enable_half), 32'd0);

    // Reset in the middle of the data segment, with a word offered that cycle
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_clear();
    cur_inst = 1'b1;
    send_segment(rand_words(4), 0);
    s_valid = 1'b1; s_data = $urandom; s_last = 1'b0;
    @(negedge clk);
    s_data = $urandom; s_last = 1'b1; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    model_clear();
    check_eq("mid_reset_state", 32'(fsm_state), 32'(S_IDLE));
    check_ctrl("mid_reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_ports("mid_reset");
    do_load(rand_words(5), rand_words(4), 2);

    // Words 1,2,3: checksum 6, single-word data segment padded
    iq = {32'd1, 32'd2};
    dq = {32'd3};
    do_load(iq, dq, 0);
`ifdef MEM_LOADER_CHECKSUM_EN
    check_eq("checksum_123", checksum, 32'd6);
`endif
    check_eq("empty_seg_d2", DataExMemData2, 32'd0);

    // Randomized loads, restarted from RUN
    for (int k = 0; k < 6; k++) begin
      halt_req = 1'($urandom_range(0, 1)); #1;
      check_eq("rand_halt", 32'(enable_half), 32'(halt_req));
      halt_req = 1'b0;
      do_load(rand_words(int'($urandom_range(1, 20))),
              rand_words(int'($urandom_range(1, 12))),
              int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
